sipo_word_framer: RTL and testbench

SIPO_WORD_FRAMER -- requirements
Module: sipo_word_framer

---
 rtl/sipo_word_framer.sv | 97 +++++++++
 tb/tb_sipo_word_framer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sipo_word_framer.sv
// sipo_word_framer: hunts a serial stream for a sync pattern, then packs the
// following FRAME_WORDS words MSB-first into a small output FIFO.
module sipo_word_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int SYNC_WIDTH = 8,
  parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN = 8'hB4,
  parameter int FRAME_WORDS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  locked,
  output logic                  overflow
);
  localparam int FW = $clog2(SYNC_WIDTH + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int WW = $clog2(FRAME_WORDS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state;
  logic [SYNC_WIDTH-1:0] window, win_next;
  logic [FW-1:0] fill, fill_next;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] word_cnt;
  logic [DATA_WIDTH-1:0] word, word_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] count;
  logic sync_hit, push, frame_done, pop, accept;
  always_comb begin
    win_next = {window[SYNC_WIDTH-2:0], din};
    fill_next = fill == FILL_MAX ? fill : fill + 1'b1;
    word_next = {word[DATA_WIDTH-2:0], din};
    sync_hit = din_valid && state == HUNT && fill_next == FILL_MAX && win_next == SYNC_PATTERN;
    push = din_valid && state == LOCKED && bit_cnt == BIT_LAST;
    frame_done = push && word_cnt == WORD_LAST;
    pop = out_valid && out_ready;
    accept = push && (count != FULL || pop);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= HUNT;
      window <= '0;
      fill <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      word <= '0;
    end else if (din_valid) begin
      if (state == HUNT) begin
        window <= win_next;
        fill <= fill_next;
        if (sync_hit) begin
          state <= LOCKED;
          bit_cnt <= '0;
          word_cnt <= '0;
        end
      end else begin
        word <= word_next;
        bit_cnt <= push ? '0 : bit_cnt + 1'b1;
        if (push) word_cnt <= frame_done ? '0 : word_cnt + 1'b1;
        if (frame_done) begin
          state <= HUNT;
          window <= '0;
          fill <= '0;
        end
      end
    end
  end
  // A dropped word only raises overflow; framing above never sees backpressure.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
      if (push && !accept) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (resetn && accept) mem[wr] <= word_next;
  assign out_valid = count != '0;
  assign dout = out_valid ? mem[rd] : '0;
  assign locked = state == LOCKED;
endmodule

// File: tb/tb_sipo_word_framer.sv
// tb_sipo_word_framer: randomized and directed stimulus checked every cycle
// against a queue-based frame/FIFO reference model.
module tb_sipo_word_framer;
  logic clk = 0, resetn = 0, din = 0, din_valid = 0, out_ready = 0;
  logic [15:0] dout, dout2;
  logic out_valid, locked, overflow, out_valid2, locked2, overflow2;
  int n_chk = 0, n_pass = 0;
  int rdy_pct = 100, gap_pct = 0, bitno = 0;
  bit gap3 = 0;
  logic [15:0] q[$];
  logic [7:0] hist;
  logic [15:0] w;
  int hn, nb, nw;
  bit m_lock, m_ovf;
  sipo_word_framer dut (.clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .locked(locked), .overflow(overflow));
  sipo_word_framer #(.SYNC_PATTERN(8'h00)) dut2 (.clk(clk), .resetn(resetn), .din(din),
    .din_valid(din_valid), .dout(dout2), .out_valid(out_valid2), .out_ready(out_ready),
    .locked(locked2), .overflow(overflow2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic step(input logic b, input logic v);
    logic rdy;
    bit pop;
    rdy = $urandom_range(99) < rdy_pct;
    din = b;
    din_valid = v;
    out_ready = rdy;
    pop = resetn && q.size() != 0 && rdy;
    @(posedge clk);
    if (!resetn) begin
      q.delete();
      hist = 0; hn = 0; m_lock = 0; nb = 0; nw = 0; w = 0; m_ovf = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (v) begin
        if (!m_lock) begin
          hist = {hist[6:0], b};
          if (hn < 8) hn++;
          if (hn == 8 && hist == 8'hB4) begin m_lock = 1; nb = 0; nw = 0; end
        end else begin
          w = {w[14:0], b};
          nb++;
          if (nb == 16) begin
            if (q.size() < 4) q.push_back(w); else m_ovf = 1;
            nb = 0;
            nw++;
            if (nw == 4) begin m_lock = 0; hn = 0; hist = 0; end
          end
        end
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("dout", 32'(dout), 32'(q[0]));
    if (!resetn) check("dout_rst", 32'(dout), 0);
    check("locked", 32'(locked), 32'(m_lock));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) step(1'($urandom_range(1)), 0);
      if (gap3 && bitno % 3 == 2) step(1'($urandom_range(1)), 0);
      step(val[i], 1);
      bitno++;
    end
  endtask
  task automatic send_frame(input logic [15:0] a, b, c, d);
    send_bits(32'hB4, 8);
    send_bits(32'(a), 16);
    send_bits(32'(b), 16);
    send_bits(32'(c), 16);
    send_bits(32'(d), 16);
  endtask
  task automatic do_reset();
    resetn = 0;
    step(0, 0);
    step(0, 0);
    resetn = 1;
  endtask
  initial begin
    do_reset();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_ovf", 32'(overflow), 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1);
      check("lock00", 32'(locked2), 32'(i == 8));
    end
    do_reset();
    rdy_pct = 100;
    send_frame(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
    repeat (3) step(0, 0);
    gap3 = 1;
    send_bits(32'b01101, 5);
    send_frame(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
    gap3 = 0;
    repeat (3) step(0, 0);
    do_reset();
    rdy_pct = 0;
    send_frame(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678);
    step(0, 0);
    check("full_valid", 32'(out_valid), 1);
    check("full_head", 32'(dout), 32'hDEAD);
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    check("ovf_set", 32'(overflow), 1);
    rdy_pct = 100;
    repeat (8) step(0, 0);
    check("ovf_sticky", 32'(overflow), 1);
    do_reset();
    rdy_pct = 0;
    send_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    send_bits(32'hB4, 8);
    send_bits(32'h5A5A >> 1, 15);
    rdy_pct = 100;
    step(1'b0, 1);
    rdy_pct = 0;
    check("full_pop_ovf", 32'(overflow), 0);
    send_bits(32'h6666, 16);
    rdy_pct = 100;
    repeat (8) step(0, 0);
    do_reset();
    send_bits(32'hB4, 8);
    send_bits(32'hCAFE, 16);
    send_bits(32'h3FF, 10);
    do_reset();
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_locked", 32'(locked), 0);
    send_bits(32'hFFFF, 16);
    check("no_sync_valid", 32'(out_valid), 0);
    for (int k = 0; k < 25; k++) begin
      gap_pct = $urandom_range(30);
      rdy_pct = $urandom_range(100);
      send_bits($urandom, $urandom_range(12));
      if ($urandom_range(7) == 0) begin
        send_bits(32'hB4, 8);
        send_bits($urandom, $urandom_range(40));
        do_reset();
      end else
        send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    gap_pct = 0;
    rdy_pct = 100;
    repeat (6) step(0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
